sbp_lookup_stage_rw: RTL and testbench
======================================

// Module: sbp_lookup_stage_rw
// PURPOSE
// Parametrised next-generation stage of the scalable pipelined prefix lookup.
// - Owns its node memory and clears it after reset with an init sweep.
// - Adds a runtime node-write port, a valid-qualified 2-cycle pipeline, IPv4/IPv6 key width
//   and a per-node has_result flag.
// - Stages chain output-to-input. Stage 1 is fed by the lookup ingress; the last stage drives
//   the result collector.
// PARAMETERS
// STAGE_ID       1    id this stage answers to; must be >=1 (0 = "lookup finished")
// STAGE_ID_BITS  6    width of stage id
// LOCATION_BITS  11   node address width; memory depth = 2**LOCATION_BITS
// KEY_BITS       32   lookup key width (32 IPv4, 128 IPv6)
// POS_BITS       8    width of bit_pos and prefix_length; must satisfy 2**POS_BITS > KEY_BITS
// local RES_BITS  = STAGE_ID_BITS+LOCATION_BITS
// local WORD_BITS = KEY_BITS+POS_BITS+STAGE_ID_BITS+LOCATION_BITS+1
// PORTS
// clk          in   1          clock
// rst          in   1          synchronous active-high reset
// valid_i      in   1          lookup token present
// bit_pos_i    in   POS_BITS   key bit examined at this tree level (0 = MSB)
// stage_id_i   in   STAGE_ID_BITS   stage holding the next node
// location_i   in   LOCATION_BITS   node address in that stage
// result_i     in   RES_BITS   best match so far {stage_id,location}
// key_i        in   KEY_BITS   lookup key
// valid_o, bit_pos_o, stage_id_o, location_o, result_o, key_o   out   same widths as inputs
// upd_wr_i     in   1          node write strobe
// upd_addr_i   in   LOCATION_BITS   node write address
// upd_data_i   in   WORD_BITS  {prefix,prefix_len,child_stage_id,child_location,has_result}
// init_done_o  out  1          memory sweep finished; stage operational
// BEHAVIOUR
// - FSM INIT->RUN.
//   - rst (also mid-sweep) -> INIT, sweep counter=0.
//   - INIT writes all-zero words at counter, incrementing by 1 per cycle.
//   - After address 2**LOCATION_BITS-1 is written, go to RUN next cycle (sweep = 2**LOCATION_BITS cycles).
// - In INIT: valid_i and upd_wr_i are ignored (tokens dropped), init_done_o=0, valid_o=0.
// - Reset values: all outputs 0, init_done_o=0, pipeline valids 0. Memory contents come only from the sweep.
// - Pipeline, latency exactly 2 cycles, no backpressure, one token per cycle.
//   - C0: memory read at location_i; all inputs registered.
//   - C1: memory word available; decode is combinational.
//   - C2: outputs registered.
// - Non-valid tokens propagate valid_o=0. Other outputs then hold their last value; don't-care.
// - sel = valid && stage_id_d==STAGE_ID. Unselected tokens pass all fields unchanged.
// - match = prefix_len==0, OR the top min(prefix_len,KEY_BITS) bits of key equal prefix.
//   - prefix_len>=KEY_BITS compares the full key.
//   - No shift by >=KEY_BITS is allowed.
// - right = key bit at bit_pos (MSB-first). bit_pos>=KEY_BITS -> right=0.
// - When sel:
//   - stage_id_o = child_stage_id.
//   - location_o = child_location+right, mod 2**LOCATION_BITS (wraps).
//   - bit_pos_o = bit_pos+1, saturating at 2**POS_BITS-1.
//   - result_o = {stage_id,location} if match && has_result, else result_i.
// - child_stage_id=0 terminates: every later stage passes the token through.
// - key_o always = key_i delayed.
// - upd_wr_i in RUN writes upd_data_i at upd_addr_i.
//   - Write and lookup read to the same address in the same cycle: the read returns OLD data.
//   - The new word is visible to reads issued from the next cycle.
// TESTING
// 1 rst 1 cycle, LOCATION_BITS=4 -> init_done_o rises exactly 16 cycles after rst falls;
//   valid_i asserted during the sweep never produces valid_o.
// 2 Write addr5 = {prefix 0x0A000000, len 8, child stage 2, loc 6, has_result 1};
//   token stage1 loc5 bit_pos 8, key 0x0A800000 -> 2 cycles later:
//   stage_id_o=2, location_o=7, bit_pos_o=9, result_o={1,5}.
// 3 Same node, key 0x0B000000 -> result_o unchanged from result_i.
//   Same node with has_result=0 -> result_o=result_i.
// 4 Token with stage_id_i=3 to STAGE_ID=1 -> all fields delayed 2 cycles, unchanged.
//   stage_id_i=0 -> unchanged.
// 5 child_location=0x7FF, right=1 -> location_o=0.
//   len=0 always matches. len=40 with KEY_BITS=32 matches on full equality only.
// 6 Back-to-back tokens every cycle with upd_wr_i hitting the read address in the same cycle
//   -> first read old word, next read new word.
//   rst mid-sweep restarts the counter at 0.

Source files
------------

// File: rtl/sbp_lookup_stage_rw.sv
// One stage of the pipelined prefix-lookup tree.
// Owns its node memory, clears it with an address sweep after reset, accepts
// runtime node writes, and evaluates one node per token through a 2-cycle pipeline.
//
// Token interface: valid_i marks a token in a cycle. There is no ready signal.
// The stage accepts one token per cycle. valid_o follows exactly 2 cycles later.
// Tokens offered while init_done_o is low are discarded.
module sbp_lookup_stage_rw #(
    parameter int STAGE_ID      = 1,
    parameter int STAGE_ID_BITS = 6,
    parameter int LOCATION_BITS = 11,
    parameter int KEY_BITS      = 32,
    parameter int POS_BITS      = 8,
    localparam int RES_BITS     = STAGE_ID_BITS + LOCATION_BITS,
    localparam int WORD_BITS    = KEY_BITS + POS_BITS + STAGE_ID_BITS + LOCATION_BITS + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [POS_BITS-1:0]      bit_pos_i,
    input  logic [STAGE_ID_BITS-1:0] stage_id_i,
    input  logic [LOCATION_BITS-1:0] location_i,
    input  logic [RES_BITS-1:0]      result_i,
    input  logic [KEY_BITS-1:0]      key_i,
    output logic                     valid_o,
    output logic [POS_BITS-1:0]      bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
    output logic [RES_BITS-1:0]      result_o,
    output logic [KEY_BITS-1:0]      key_o,
    input  logic                     upd_wr_i,
    input  logic [LOCATION_BITS-1:0] upd_addr_i,
    input  logic [WORD_BITS-1:0]     upd_data_i,
    output logic                     init_done_o,
    output logic                     dbg_state
);

    localparam logic [POS_BITS-1:0]      KEY_BITS_P = POS_BITS'(KEY_BITS);
    localparam logic [STAGE_ID_BITS-1:0] MY_ID      = STAGE_ID_BITS'(STAGE_ID);
    localparam logic [LOCATION_BITS-1:0] LAST_ADDR  = '1;
    localparam logic [POS_BITS-1:0]      POS_MAX    = '1;

    // Bit offsets of the fields within a node word.
    localparam int CLOC_LO = 1;
    localparam int CSID_LO = CLOC_LO + LOCATION_BITS;
    localparam int LEN_LO  = CSID_LO + STAGE_ID_BITS;
    localparam int PFX_LO  = LEN_LO + POS_BITS;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                   state;
    logic [LOCATION_BITS-1:0] sweep_cnt;

    logic [WORD_BITS-1:0]     mem [2**LOCATION_BITS];
    logic [WORD_BITS-1:0]     rdata;
    logic                     mem_we;
    logic [LOCATION_BITS-1:0] mem_waddr;
    logic [WORD_BITS-1:0]     mem_wdata;

    // Stage-1 token registers, aligned with rdata.
    logic                     valid_d;
    logic [POS_BITS-1:0]      bit_pos_d;
    logic [STAGE_ID_BITS-1:0] stage_id_d;
    logic [LOCATION_BITS-1:0] location_d;
    logic [RES_BITS-1:0]      result_d;
    logic [KEY_BITS-1:0]      key_d;

    // Decoded node fields.
    logic [KEY_BITS-1:0]      w_prefix;
    logic [POS_BITS-1:0]      w_len;
    logic [STAGE_ID_BITS-1:0] w_child_sid;
    logic [LOCATION_BITS-1:0] w_child_loc;
    logic                     w_has_result;

    logic                     sel;
    logic                     match;
    logic                     right;
    logic [POS_BITS-1:0]      eff_len;
    logic [POS_BITS-1:0]      shamt;
    logic [KEY_BITS-1:0]      mask;
    logic [KEY_BITS-1:0]      key_shifted;
    logic [LOCATION_BITS-1:0] next_loc;
    logic [POS_BITS-1:0]      next_pos;

    assign dbg_state = state;

    // Memory write source: the zeroing sweep during INIT, the update port during RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sweep_cnt;
        mem_wdata = '0;
        if (!rst) begin
            if (state == ST_INIT) begin
                mem_we = 1'b1;
            end else if (upd_wr_i) begin
                mem_we    = 1'b1;
                mem_waddr = upd_addr_i;
                mem_wdata = upd_data_i;
            end
        end
    end

    // Node memory. Read-first, so a same-cycle write to the read address returns old data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rdata <= mem[location_i];
    end

    // INIT/RUN controller. The sweep writes one address per cycle and ends on the last address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            sweep_cnt   <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_cnt <= sweep_cnt + LOCATION_BITS'(1);
                    if (sweep_cnt == LAST_ADDR) begin
                        state       <= ST_RUN;
                        init_done_o <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Register the token alongside the memory read. Tokens offered before RUN are dropped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d    <= 1'b0;
            bit_pos_d  <= '0;
            stage_id_d <= '0;
            location_d <= '0;
            result_d   <= '0;
            key_d      <= '0;
        end else begin
            valid_d    <= valid_i && (state == ST_RUN);
            bit_pos_d  <= bit_pos_i;
            stage_id_d <= stage_id_i;
            location_d <= location_i;
            result_d   <= result_i;
            key_d      <= key_i;
        end
    end

    assign w_has_result = rdata[0];
    assign w_child_loc  = rdata[CSID_LO-1:CLOC_LO];
    assign w_child_sid  = rdata[LEN_LO-1:CSID_LO];
    assign w_len        = rdata[PFX_LO-1:LEN_LO];
    assign w_prefix     = rdata[WORD_BITS-1:PFX_LO];

    assign sel = valid_d && (stage_id_d == MY_ID);

    // Node decode: prefix match over the top min(len, KEY_BITS) bits and the branch direction.
    always_comb begin
        eff_len     = '0;
        shamt       = '0;
        mask        = '0;
        match       = 1'b1;
        key_shifted = '0;
        right       = 1'b0;
        if (w_len != '0) begin
            eff_len = (w_len >= KEY_BITS_P) ? KEY_BITS_P : w_len;
            shamt   = KEY_BITS_P - eff_len;
            mask    = {KEY_BITS{1'b1}} << shamt;
            match   = ((key_d ^ w_prefix) & mask) == '0;
        end
        if (bit_pos_d < KEY_BITS_P) begin
            key_shifted = key_d << bit_pos_d;
            right       = key_shifted[KEY_BITS-1];
        end
        next_loc = w_child_loc + {{(LOCATION_BITS-1){1'b0}}, right};
        next_pos = (bit_pos_d == POS_MAX) ? bit_pos_d : bit_pos_d + POS_BITS'(1);
    end

    // Output registers: a selected token takes the node's decision, others pass unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            bit_pos_o  <= '0;
            stage_id_o <= '0;
            location_o <= '0;
            result_o   <= '0;
            key_o      <= '0;
        end else begin
            valid_o <= valid_d;
            if (valid_d) begin
                key_o <= key_d;
                if (sel) begin
                    stage_id_o <= w_child_sid;
                    location_o <= next_loc;
                    bit_pos_o  <= next_pos;
                    result_o   <= (match && w_has_result) ? {stage_id_d, location_d} : result_d;
                end else begin
                    stage_id_o <= stage_id_d;
                    location_o <= location_d;
                    bit_pos_o  <= bit_pos_d;
                    result_o   <= result_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbp_lookup_stage_rw.sv
// Bench for sbp_lookup_stage_rw: a default-size stage for lookup behaviour and
// a 16-entry stage for exact sweep timing and mid-sweep reset.
module tb_sbp_lookup_stage_rw;

    localparam int EXP_W = 8 + 6 + 11 + 17 + 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  bit_pos_i;
    logic [5:0]  stage_id_i;
    logic [10:0] location_i;
    logic [16:0] result_i;
    logic [31:0] key_i;
    logic        upd_wr_i;
    logic [10:0] upd_addr_i;
    logic [57:0] upd_data_i;
    logic        valid_o;
    logic [7:0]  bit_pos_o;
    logic [5:0]  stage_id_o;
    logic [10:0] location_o;
    logic [16:0] result_o;
    logic [31:0] key_o;
    logic        init_done_o;
    logic        dbg_state;

    // Small instance signals
    logic        rst_s;
    logic        valid_s;
    logic        upd_wr_s;
    logic [50:0] upd_data_s;
    logic        valid_o_s;
    logic [7:0]  bit_pos_o_s;
    logic [5:0]  stage_id_o_s;
    logic [3:0]  location_o_s;
    logic [9:0]  result_o_s;
    logic [31:0] key_o_s;
    logic        init_done_s;
    logic        dbg_state_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [EXP_W-1:0] exp_q[$];
    int               lat_q[$];

    sbp_lookup_stage_rw dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .bit_pos_i(bit_pos_i),
        .stage_id_i(stage_id_i), .location_i(location_i), .result_i(result_i), .key_i(key_i),
        .valid_o(valid_o), .bit_pos_o(bit_pos_o), .stage_id_o(stage_id_o),
        .location_o(location_o), .result_o(result_o), .key_o(key_o),
        .upd_wr_i(upd_wr_i), .upd_addr_i(upd_addr_i), .upd_data_i(upd_data_i),
        .init_done_o(init_done_o), .dbg_state(dbg_state)
    );

    sbp_lookup_stage_rw #(.LOCATION_BITS(4)) dut_s (
        .clk(clk), .rst(rst_s), .valid_i(valid_s), .bit_pos_i(bit_pos_i),
        .stage_id_i(stage_id_i), .location_i(location_i[3:0]), .result_i(result_i[9:0]),
        .key_i(key_i),
        .valid_o(valid_o_s), .bit_pos_o(bit_pos_o_s), .stage_id_o(stage_id_o_s),
        .location_o(location_o_s), .result_o(result_o_s), .key_o(key_o_s),
        .upd_wr_i(upd_wr_s), .upd_addr_i(upd_addr_i[3:0]), .upd_data_i(upd_data_s),
        .init_done_o(init_done_s), .dbg_state(dbg_state_s)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drivers
    task automatic wr(input logic [10:0] addr, input logic [31:0] pfx, input logic [7:0] len,
                      input logic [5:0] csid, input logic [10:0] cloc, input logic hr);
        upd_wr_i   = 1'b1;
        upd_addr_i = addr;
        upd_data_i = {pfx, len, csid, cloc, hr};
        tick();
        upd_wr_i   = 1'b0;
    endtask

    task automatic put(input logic [7:0] bp, input logic [5:0] sid, input logic [10:0] loc,
                       input logic [16:0] res, input logic [31:0] key,
                       input logic [7:0] ebp, input logic [5:0] esid, input logic [10:0] eloc,
                       input logic [16:0] eres);
        valid_i    = 1'b1;
        bit_pos_i  = bp;
        stage_id_i = sid;
        location_i = loc;
        result_i   = res;
        key_i      = key;
        exp_q.push_back({ebp, esid, eloc, eres, key});
        lat_q.push_back(cyc + 2);
    endtask

    task automatic tok(input logic [7:0] bp, input logic [5:0] sid, input logic [10:0] loc,
                       input logic [16:0] res, input logic [31:0] key,
                       input logic [7:0] ebp, input logic [5:0] esid, input logic [10:0] eloc,
                       input logic [16:0] eres);
        put(bp, sid, loc, res, key, ebp, esid, eloc, eres);
        tick();
        valid_i = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid_o got=%0h expected=none",
                         {bit_pos_o, stage_id_o, location_o, result_o, key_o});
            end else begin
                logic [EXP_W-1:0] e;
                int l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                chk("token_fields", {bit_pos_o, stage_id_o, location_o, result_o, key_o}, e);
                chk("token_latency", cyc, l);
            end
        end
    end

    int main_done;
    int small_done;
    int small_leak;

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        valid_i = 1'b1; valid_s = 1'b1;
        bit_pos_i = '0; stage_id_i = 6'd1; location_i = '0; result_i = '0; key_i = '0;
        upd_wr_i = 1'b0; upd_addr_i = '0; upd_data_i = '0;
        upd_wr_s = 1'b0; upd_data_s = '0;
        main_done = 0; small_done = 0; small_leak = 0;
        tick();
        chk("reset_valid_o", valid_o, 0);
        chk("reset_init_done", init_done_o, 0);
        chk("reset_outputs", {bit_pos_o, stage_id_o, location_o, result_o, key_o}, 0);
        chk("reset_small_init_done", init_done_s, 0);
        rst = 1'b0; rst_s = 1'b0;

        // Sweep timing; valid held high throughout must never reach valid_o.
        for (int k = 1; k <= 3000 && main_done == 0; k++) begin
            tick();
            if (valid_o_s && small_done == 0) small_leak = 1;
            if (init_done_s && small_done == 0) begin
                small_done = k;
                valid_s = 1'b0;
            end
            if (init_done_o && main_done == 0) begin
                main_done = k;
                valid_i = 1'b0;
            end
        end
        chk("small_sweep_cycles", small_done, 16);
        chk("main_sweep_cycles", main_done, 2048);
        chk("small_no_valid_in_sweep", small_leak, 0);

        // Mid-sweep reset on the small stage restarts the count.
        rst_s = 1'b1; valid_s = 1'b1; tick(); rst_s = 1'b0;
        repeat (5) tick();
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        chk("small_init_done_after_rst", init_done_s, 0);
        small_done = 0;
        for (int k = 1; k <= 40 && small_done == 0; k++) begin
            tick();
            if (valid_o_s && small_done == 0) small_leak = 1;
            if (init_done_s) begin
                small_done = k;
                valid_s = 1'b0;
            end
        end
        chk("small_resweep_cycles", small_done, 16);
        chk("small_no_valid_in_resweep", small_leak, 0);

        // Node programming
        wr(11'd5, 32'h0A000000, 8'd8, 6'd2, 11'd6, 1'b1);
        wr(11'd6, 32'h0A000000, 8'd8, 6'd2, 11'd6, 1'b0);
        wr(11'd7, 32'h00000000, 8'd0, 6'd4, 11'h7FF, 1'b1);
        wr(11'd8, 32'h12345678, 8'd40, 6'd5, 11'h010, 1'b1);
        wr(11'd9, 32'h00000000, 8'd0, 6'd3, 11'h020, 1'b0);
        tick();

        // Match, branch right, result updated
        tok(8'd8, 6'd1, 11'd5, 17'h0, 32'h0A800000, 8'd9, 6'd2, 11'd7, 17'h805);
        // Mismatch, branch left
        tok(8'd8, 6'd1, 11'd5, 17'h123, 32'h0B000000, 8'd9, 6'd2, 11'd6, 17'h123);
        // has_result clear
        tok(8'd8, 6'd1, 11'd6, 17'h0AB, 32'h0A800000, 8'd9, 6'd2, 11'd7, 17'h0AB);
        // Other stage and terminated token pass through
        tok(8'd4, 6'd3, 11'd5, 17'h055, 32'hDEADBEEF, 8'd4, 6'd3, 11'd5, 17'h055);
        tok(8'd9, 6'd0, 11'd5, 17'h077, 32'h0A800000, 8'd9, 6'd0, 11'd5, 17'h077);
        // Location wrap, len 0 matches
        tok(8'd31, 6'd1, 11'd7, 17'h0, 32'h00000001, 8'd32, 6'd4, 11'd0, 17'h807);
        // len 40 matches only on full key equality; bit_pos>=32 branches left
        tok(8'd40, 6'd1, 11'd8, 17'h111, 32'h12345678, 8'd41, 6'd5, 11'h010, 17'h808);
        tok(8'd40, 6'd1, 11'd8, 17'h111, 32'h12345679, 8'd41, 6'd5, 11'h010, 17'h111);
        // bit_pos saturation
        tok(8'd255, 6'd1, 11'd9, 17'h042, 32'hFFFFFFFF, 8'd255, 6'd3, 11'h020, 17'h042);

        // Back-to-back with a same-cycle write to the read address
        put(8'd0, 6'd1, 11'd10, 17'h001, 32'h80000000, 8'd1, 6'd0, 11'd1, 17'h001);
        upd_wr_i   = 1'b1;
        upd_addr_i = 11'd10;
        upd_data_i = {32'h0, 8'd0, 6'd6, 11'h030, 1'b1};
        tick();
        upd_wr_i = 1'b0;
        put(8'd0, 6'd1, 11'd10, 17'h001, 32'h80000000, 8'd1, 6'd6, 11'h031, 17'h80A);
        tick();
        put(8'd2, 6'd2, 11'd10, 17'h003, 32'h12121212, 8'd2, 6'd2, 11'd10, 17'h003);
        tick();
        valid_i = 1'b0;

        // Drain
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
